// File: rtl/captura_botones_if.sv
// Request handshake between the button front end and the request memory.
// The producer (captura_botones) drives boton_pres/valido; the consumer drives listo.
interface captura_botones_if;
  logic [3:0] boton_pres;
  logic       valido;
  logic       listo;

  modport master (output boton_pres, output valido, input listo);
  modport slave  (input boton_pres, input valido, output listo);
endinterface

// File: rtl/captura_botones.sv
// Elevator button front end: sync + debounce 10 buttons, latch presses, offer them round-robin.
// Optional macro CAPTURA_BOTONES_LUCES_EN adds the luces[9:0] call-acknowledge lamp output.
module captura_botones #(
  parameter int DEB_CICLOS = 4,
  parameter int N_BOTONES  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_BOTONES-1:0] btn,
  captura_botones_if.master    bus
`ifdef CAPTURA_BOTONES_LUCES_EN
  ,
  output logic [N_BOTONES-1:0] luces
`endif
);

  localparam int CW = $clog2(DEB_CICLOS + 1);

  typedef enum logic {VACIO, OFRECE} estado_t;

  logic [N_BOTONES-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [N_BOTONES-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CW-1:0]        cnt_q [N_BOTONES];
  logic [CW-1:0]        cnt_d [N_BOTONES];
  logic [N_BOTONES-1:0] pending_q, pending_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [3:0]           code_q, code_d;
  logic                 valido_q, valido_d;
  estado_t              estado_q, estado_d;

  logic [N_BOTONES-1:0] press, offered, clr;
  logic                 sel_found, load;
  logic [3:0]           sel_idx;

  always_comb begin
    s1_d       = btn;
    s2_d       = s1_q;
    deb_prev_d = deb_q;
    for (int unsigned i = 0; i < N_BOTONES; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        // The DEB_CICLOS-th consecutive mismatch flips the level and clears the count.
        if (cnt_q[i] == CW'(DEB_CICLOS - 1)) deb_d[i] = s2_q[i];
        else                                 cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // Round-robin search: first pending index starting at ptr, wrapping past the top.
  always_comb begin
    int unsigned cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_BOTONES; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_BOTONES) cand = cand - N_BOTONES;
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = 4'(cand);
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    valido_d = valido_q;
    code_d   = code_q;
    ptr_d    = ptr_q;
    clr      = '0;
    load     = en && sel_found && ((estado_q == VACIO) || bus.listo);
    if (load) begin
      estado_d     = OFRECE;
      valido_d     = 1'b1;
      code_d       = sel_idx + 4'd1;
      clr[sel_idx] = 1'b1;
      ptr_d        = (sel_idx == 4'(N_BOTONES - 1)) ? 4'd0 : sel_idx + 4'd1;
    end else if (estado_q == OFRECE && bus.listo) begin
      estado_d = VACIO;
      valido_d = 1'b0;
      code_d   = '0;
    end
  end

  // A press of the code on offer (old or newly loaded) is merged into that request.
  always_comb begin
    for (int unsigned i = 0; i < N_BOTONES; i++)
      offered[i] = valido_q && (code_q == 4'(i + 1));
    pending_d = (pending_q & ~clr) | (press & ~offered & ~clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int unsigned i = 0; i < N_BOTONES; i++) cnt_q[i] <= '0;
      pending_q  <= '0;
      ptr_q      <= '0;
      code_q     <= '0;
      valido_q   <= 1'b0;
      estado_q   <= VACIO;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int unsigned i = 0; i < N_BOTONES; i++) cnt_q[i] <= cnt_d[i];
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      code_q     <= code_d;
      valido_q   <= valido_d;
      estado_q   <= estado_d;
    end
  end

  assign bus.boton_pres = code_q;
  assign bus.valido     = valido_q;

`ifdef CAPTURA_BOTONES_LUCES_EN
  logic [N_BOTONES-1:0] luces_q, luces_d;

  always_comb begin
    for (int unsigned i = 0; i < N_BOTONES; i++)
      luces_d[i] = pending_d[i] | (valido_d && (code_d == 4'(i + 1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) luces_q <= '0;
    else      luces_q <= luces_d;
  end

  assign luces = luces_q;
`endif

endmodule
